// File: rtl/execute_mdu.sv
// rtl/execute_mdu.sv - RV32 execute stage: registered ALU/branch/PC-target paths plus iterative RV32M unit
// Optional EXECUTE_MDU_EARLY_OUT_EN: divide-by-zero and signed-overflow divides retire in one cycle.
module execute_mdu #(
    parameter int DATA_WIDTH    = 32,
    parameter int BRANCH_TYPE_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     is_m,
    input  logic [2:0]               m_funct3,
    input  logic [3:0]               alu_control,
    input  logic                     ALUSrcA,
    input  logic                     ALUSrcB,
    input  logic                     PCTargetSrc,
    input  logic                     Branch,
    input  logic [BRANCH_TYPE_W-1:0] branchType,
    input  logic [DATA_WIDTH-1:0]    PC,
    input  logic [DATA_WIDTH-1:0]    rs1,
    input  logic [DATA_WIDTH-1:0]    rs2,
    input  logic [DATA_WIDTH-1:0]    imm_ext,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic [DATA_WIDTH-1:0]    PCTarget,
    output logic                     branch_taken,
    output logic                     busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state, state_next;

    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opb;
    logic [2:0]     f3;
    logic           neg;
    logic           accept;

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid & in_ready & ~flush;

    logic [W-1:0]  op1, op2, alu_res, pc_target, pc_imm;
    logic [CW-1:0] shamt;
    always_comb begin
        op1   = ALUSrcA ? PC : rs1;
        op2   = ALUSrcB ? imm_ext : rs2;
        shamt = op2[CW-1:0];
        case (alu_control)
            4'd0:    alu_res = op1 + op2;
            4'd1:    alu_res = op1 - op2;
            4'd2:    alu_res = op1 & op2;
            4'd3:    alu_res = op1 | op2;
            4'd4:    alu_res = op1 ^ op2;
            4'd5:    alu_res = {{(W-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'd6:    alu_res = {{(W-1){1'b0}}, op1 < op2};
            4'd7:    alu_res = op1 << shamt;
            4'd8:    alu_res = op1 >> shamt;
            4'd9:    alu_res = $signed(op1) >>> shamt;
            4'd10:   alu_res = op2;
            default: alu_res = '0;
        endcase
        pc_target = (PCTargetSrc ? rs1 : PC) + imm_ext;
        pc_imm    = PC + imm_ext;
    end

    logic cond, taken;
    always_comb begin
        case (branchType)
            BRANCH_TYPE_W'(0): cond = (rs1 == rs2);
            BRANCH_TYPE_W'(1): cond = (rs1 != rs2);
            BRANCH_TYPE_W'(4): cond = ($signed(rs1) < $signed(rs2));
            BRANCH_TYPE_W'(5): cond = ($signed(rs1) >= $signed(rs2));
            BRANCH_TYPE_W'(6): cond = (rs1 < rs2);
            BRANCH_TYPE_W'(7): cond = (rs1 >= rs2);
            default:           cond = 1'b0;
        endcase
        taken = Branch & cond;
    end

    // Work on magnitudes; neg_in records whether the selected result must be negated in FIX.
    logic         sgn_a, sgn_b, sa, sb, neg_in;
    logic [W-1:0] abs_a, abs_b;
    always_comb begin
        sgn_a = (m_funct3 == 3'b001) | (m_funct3 == 3'b010) | (m_funct3 == 3'b100) | (m_funct3 == 3'b110);
        sgn_b = (m_funct3 == 3'b001) | (m_funct3 == 3'b100) | (m_funct3 == 3'b110);
        sa    = sgn_a & rs1[W-1];
        sb    = sgn_b & rs2[W-1];
        abs_a = sa ? -rs1 : rs1;
        abs_b = sb ? -rs2 : rs2;
        if (!m_funct3[2])     neg_in = sa ^ sb;
        else if (m_funct3[1]) neg_in = sa;
        else                  neg_in = (sa ^ sb) & (rs2 != '0);
    end

    logic         early;
    logic [W-1:0] early_res;
`ifdef EXECUTE_MDU_EARLY_OUT_EN
    always_comb begin
        early     = 1'b0;
        early_res = '0;
        if (is_m && m_funct3[2]) begin
            if (rs2 == '0) begin
                early     = 1'b1;
                early_res = m_funct3[1] ? rs1 : '1;
            end else if (!m_funct3[0] && rs1 == {1'b1, {(W-1){1'b0}}} && rs2 == '1) begin
                early     = 1'b1;
                early_res = m_funct3[1] ? '0 : rs1;
            end
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
    logic [W:0]     mul_sum, div_diff;
    logic [2*W-1:0] acc_step, prod;
    logic [W-1:0]   div_sel, fix_res;
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opb : {W{1'b0}})};
        div_diff = acc[2*W-1:W-1] - {1'b0, opb};
        if (f3[2])
            acc_step = div_diff[W] ? {acc[2*W-2:0], 1'b0} : {div_diff[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_step = {mul_sum, acc[W-1:1]};
        prod    = neg ? -acc : acc;
        div_sel = f3[1] ? acc[2*W-1:W] : acc[W-1:0];
        if (f3[2])                 fix_res = neg ? -div_sel : div_sel;
        else if (f3[1:0] == 2'b00) fix_res = prod[W-1:0];
        else                       fix_res = prod[2*W-1:W];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_m && !early) state_next = ITER;
            ITER:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush && state != IDLE) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            ALUResult    <= '0;
            PCTarget     <= '0;
            branch_taken <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            opb          <= '0;
            f3           <= '0;
            neg          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_m) begin
                ALUResult    <= alu_res;
                PCTarget     <= pc_target;
                branch_taken <= taken;
                out_valid    <= 1'b1;
            end else if (accept) begin
                PCTarget     <= pc_imm;
                branch_taken <= 1'b0;
                if (early) begin
                    ALUResult <= early_res;
                    out_valid <= 1'b1;
                end else begin
                    acc <= {{W{1'b0}}, (m_funct3[2] ? abs_a : abs_b)};
                    opb <= m_funct3[2] ? abs_b : abs_a;
                    f3  <= m_funct3;
                    neg <= neg_in;
                    cnt <= CW'(W-1);
                end
            end else if (state == ITER && !flush) begin
                acc <= acc_step;
                cnt <= cnt - 1'b1;
            end else if (state == FIX && !flush) begin
                ALUResult <= fix_res;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_execute_mdu.sv
// tb/tb_execute_mdu.sv - randomized self-checking bench for execute_mdu against an arithmetic reference model
module tb_execute_mdu;
    localparam int W = 32;
`ifdef EXECUTE_MDU_EARLY_OUT_EN
    localparam int EL = 1;
`else
    localparam int EL = W + 2;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, is_m, ALUSrcA, ALUSrcB, PCTargetSrc, Branch;
    logic [2:0]  m_funct3, branchType;
    logic [3:0]  alu_control;
    logic [31:0] PC, rs1, rs2, imm_ext;
    logic        in_ready, out_valid, branch_taken, busy;
    logic [31:0] ALUResult, PCTarget;

    always #5 clk = ~clk;

    execute_mdu #(.DATA_WIDTH(W), .BRANCH_TYPE_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .is_m(is_m), .m_funct3(m_funct3), .alu_control(alu_control), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCTargetSrc(PCTargetSrc), .Branch(Branch), .branchType(branchType),
        .PC(PC), .rs1(rs1), .rs2(rs2), .imm_ext(imm_ext), .out_valid(out_valid),
        .ALUResult(ALUResult), .PCTarget(PCTarget), .branch_taken(branch_taken), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return sa >>> b[4:0];
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit br_model(logic br, logic [2:0] t, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (!br) return 1'b0;
        case (t)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mdu_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] xa, xb;
        logic [63:0] ua, ub, p;
        int si, sj, q;
        bit ovf;
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        si = a;
        sj = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = xa * xb; return p[63:32]; end
            3'd2: begin p = xa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return a;
                q = si / sj;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                q = si % sj;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit early_case(logic m, logic [2:0] f, logic [31:0] a, logic [31:0] b);
`ifdef EXECUTE_MDU_EARLY_OUT_EN
        return m && f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [31:0] pct;
        logic        taken;
        int          due;
    } exp_t;

    function automatic exp_t make_exp(int now);
        exp_t e;
        logic [31:0] a, b;
        a = ALUSrcA ? PC : rs1;
        b = ALUSrcB ? imm_ext : rs2;
        if (is_m) begin
            e.res   = mdu_model(m_funct3, rs1, rs2);
            e.pct   = PC + imm_ext;
            e.taken = 1'b0;
            e.due   = now + (early_case(is_m, m_funct3, rs1, rs2) ? 1 : W + 2);
        end else begin
            e.res   = alu_model(alu_control, a, b);
            e.pct   = (PCTargetSrc ? rs1 : PC) + imm_ext;
            e.taken = br_model(Branch, branchType, rs1, rs2);
            e.due   = now + 1;
        end
        return e;
    endfunction

    // Scoreboard: every handshake queues its expected result and due cycle; out_valid must match.
    exp_t q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   busy_left = 0;
    int   pulses = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (out_valid) begin
                pulses++;
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("latency", cyc, mon_e.due);
                    check("result", ALUResult, mon_e.res);
                    check("pc_target", PCTarget, mon_e.pct);
                    check("branch_taken", branch_taken, mon_e.taken);
                end
            end else if (q.size() != 0 && cyc >= q[0].due) begin
                check("missing_out_valid", 32'd0, 32'd1);
                mon_e = q.pop_front();
            end
            check("in_ready", in_ready, busy_left == 0);
            check("busy", busy, busy_left != 0);
            if (rst || flush) begin
                q.delete();
                busy_left = 0;
            end else if (in_valid && in_ready) begin
                q.push_back(make_exp(cyc));
                busy_left = (is_m && !early_case(is_m, m_funct3, rs1, rs2)) ? W + 1 : 0;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
    end

    task automatic set_base(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        is_m = 1'b0; m_funct3 = 3'd0; alu_control = op;
        ALUSrcA = 1'b0; ALUSrcB = 1'b0; PCTargetSrc = 1'b0; Branch = 1'b0; branchType = 3'd0;
        PC = 32'h100; rs1 = a; rs2 = b; imm_ext = 32'h20;
    endtask

    task automatic set_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        set_base(4'd0, a, b);
        is_m = 1'b1; m_funct3 = f; PC = 32'h200; imm_ext = 32'h10;
    endtask

    task automatic issue(output logic [31:0] res, output logic [31:0] pct, output logic tk,
                         output int lat, output int low);
        int k;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        low = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready) low++;
        end while (!out_valid && lat < 100);
        check("op_done", out_valid, 1'b1);
        res = ALUResult;
        pct = PCTarget;
        tk  = branch_taken;
        @(posedge clk); #1;
    endtask

    task automatic m_case(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res, pct;
        logic tk;
        int lat, low;
        set_m(f, a, b);
        issue(res, pct, tk, lat, low);
        check(tag, res, exp);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_ready_low"}, low, exp_lat - 1);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'd1;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op();
        is_m        = 1'($urandom_range(0, 1));
        m_funct3    = 3'($urandom_range(0, 7));
        alu_control = 4'($urandom_range(0, 11));
        ALUSrcA     = 1'($urandom_range(0, 1));
        ALUSrcB     = 1'($urandom_range(0, 1));
        PCTargetSrc = 1'($urandom_range(0, 1));
        Branch      = 1'($urandom_range(0, 1));
        branchType  = 3'($urandom_range(0, 7));
        PC          = $urandom;
        rs1         = pick_val();
        rs2         = pick_val();
        imm_ext     = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, pct;
        logic tk;
        int lat, low, cnt, p0, k;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        set_base(4'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_alu_result", ALUResult, 32'd0);
        check("rst_pc_target", PCTarget, 32'd0);
        check("rst_branch_taken", branch_taken, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        set_base(4'd0, 32'd5, 32'd7);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_base(4'd1, 32'd7, 32'd5);
        @(negedge clk);
        check("add_valid", out_valid, 1'b1);
        check("add_result", ALUResult, 32'd12);
        check("add_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("sub_valid", out_valid, 1'b1);
        check("sub_result", ALUResult, 32'd2);
        @(posedge clk); #1;

        set_base(4'd1, 32'd9, 32'd9);
        Branch = 1'b1;
        issue(res, pct, tk, lat, low);
        check("beq_taken", tk, 1'b1);
        check("beq_target", pct, 32'h120);
        set_base(4'd1, 32'd9, 32'd8);
        Branch = 1'b1;
        issue(res, pct, tk, lat, low);
        check("beq_not_taken", tk, 1'b0);

        m_case("mulh", 3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, W + 2);
        m_case("mulhu", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, W + 2);
        m_case("mul", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, W + 2);
        m_case("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, W + 2);
        m_case("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, W + 2);
        m_case("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, W + 2);
        m_case("divu_zero", 3'd5, 32'd7, 32'd0, 32'hFFFFFFFF, EL);
        m_case("rem_zero", 3'd6, 32'd7, 32'd0, 32'd7, EL);
        m_case("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EL);
        m_case("div_neg_zero", 3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, EL);

        set_base(4'd0, 32'd1, 32'd1);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_drop", out_valid, 1'b0);
        @(posedge clk); #1;

        for (int pass = 0; pass < 2; pass++) begin
            set_m(3'd5, 32'd1000, 32'd7);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            if (pass == 0) flush = 1'b1;
            else           rst = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            check("abort_in_ready", in_ready, 1'b1);
            if (pass == 1) begin
                check("abort_rst_alu_result", ALUResult, 32'd0);
                check("abort_rst_pc_target", PCTarget, 32'd0);
                check("abort_rst_branch_taken", branch_taken, 1'b0);
                check("abort_rst_busy", busy, 1'b0);
            end
            cnt = 0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) cnt++;
            end
            check("abort_no_out_valid", cnt, 0);
            @(posedge clk); #1;
            set_base(4'd0, 32'd20, 32'd22);
            issue(res, pct, tk, lat, low);
            check("after_abort_add", res, 32'd42);
            check("after_abort_lat", lat, 1);
        end

        p0 = pulses;
        for (int i = 0; i < 1000; i++) begin
            rand_op();
            in_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) check("rand_ready_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 60 && q.size() != 0; j++) @(negedge clk);
        check("pulse_count", pulses - p0, 1000);
        check("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
